// File: rtl/fft_frame_stage.sv
// ---------------------------------------------------------------------------
// fft_frame_stage
//
// Streaming front-end for the spectrum FFT path. Time-interleaved complex
// samples arrive tagged with a channel number. Each channel keeps its own
// frame position counter and a {shift, bitrev} configuration that is latched
// on the first beat of every frame. Every forwarded beat is sign-extended,
// shifted left by the latched amount and tagged with its natural or
// bit-reversed index. Frame-boundary problems are flagged. A 2-entry skid
// buffer gives lossless backpressure with a registered s_ready.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   s_valid / s_ready   : input handshake (s_ready is registered)
//   s_real, s_imag      : signed input sample, DATA_W bits
//   s_chan              : channel of the input beat
//   s_last              : upstream end-of-frame marker for s_chan
//   cfg_shift           : left shift 0..4 (5..7 behave as 4)
//   cfg_bitrev          : 1 = m_index is the bit-reversed frame position
//   m_valid / m_ready   : output handshake
//   m_real, m_imag      : scaled signed sample, OUT_W bits
//   m_chan, m_index     : channel tag and index within the frame
//   m_last              : end of frame for m_chan
//   err_short/long/chan : one-cycle error pulses
//   err_sticky          : OR of all error pulses since reset
// ---------------------------------------------------------------------------
module fft_frame_stage #(
    parameter int N      = 1024,
    parameter int DATA_W = 16,
    parameter int OUT_W  = DATA_W + 5,
    parameter int NUM_CH = 1,
    localparam int IDX_W = $clog2(N),
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] s_real,
    input  logic signed [DATA_W-1:0] s_imag,
    input  logic [CH_W-1:0]          s_chan,
    input  logic                     s_last,
    input  logic [2:0]               cfg_shift,
    input  logic                     cfg_bitrev,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [OUT_W-1:0]  m_real,
    output logic signed [OUT_W-1:0]  m_imag,
    output logic [CH_W-1:0]          m_chan,
    output logic [IDX_W-1:0]         m_index,
    output logic                     m_last,
    output logic                     err_short,
    output logic                     err_long,
    output logic                     err_chan,
    output logic                     err_sticky
);

    // Per-channel state is sized to the full s_chan range so indexing never
    // goes out of bounds; entries at or above NUM_CH are never written.
    localparam int CH_DEPTH = 1 << CH_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef struct packed {
        logic signed [OUT_W-1:0] re;
        logic signed [OUT_W-1:0] im;
        logic [CH_W-1:0]         chan;
        logic [IDX_W-1:0]        index;
        logic                    last;
    } beat_t;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } state_t;

    // Registered state
    logic [IDX_W-1:0] cnt_q    [CH_DEPTH];
    logic [IDX_W-1:0] cnt_d    [CH_DEPTH];
    logic [2:0]       shift_q  [CH_DEPTH];
    logic [2:0]       shift_d  [CH_DEPTH];
    logic             bitrev_q [CH_DEPTH];
    logic             bitrev_d [CH_DEPTH];

    state_t state_q, state_d;
    beat_t  out_q, out_d;
    beat_t  skid_q, skid_d;
    logic   s_ready_q, s_ready_d;
    logic   m_valid_q, m_valid_d;
    logic   err_short_q, err_short_d;
    logic   err_long_q, err_long_d;
    logic   err_chan_q, err_chan_d;
    logic   err_sticky_q, err_sticky_d;

    // Input-side combinational signals
    logic                    accept;
    logic                    push;
    logic                    chan_bad;
    logic [IDX_W-1:0]        cur_cnt;
    logic [IDX_W-1:0]        idx_rev;
    logic                    frame_start;
    logic [2:0]              shift_clamped;
    logic [2:0]              eff_shift;
    logic                    eff_bitrev;
    logic signed [OUT_W-1:0] re_ext;
    logic signed [OUT_W-1:0] im_ext;
    beat_t                   in_beat;

    // A beat on a non-existent channel is still accepted (so upstream never
    // stalls on it) but only "push" beats reach the counters and the buffer.
    assign chan_bad = (32'(s_chan) >= 32'(NUM_CH));
    assign accept   = s_valid && s_ready_q;
    assign push     = accept && !chan_bad;

    // Build the outgoing beat. On the first beat of a frame the live cfg
    // inputs are used directly, since the latch only updates at this edge.
    always_comb begin
        cur_cnt       = cnt_q[s_chan];
        frame_start   = (cur_cnt == '0);
        shift_clamped = (cfg_shift > 3'd4) ? 3'd4 : cfg_shift;
        eff_shift     = frame_start ? shift_clamped : shift_q[s_chan];
        eff_bitrev    = frame_start ? cfg_bitrev : bitrev_q[s_chan];

        idx_rev = '0;
        for (int i = 0; i < IDX_W; i++) begin
            idx_rev[i] = cur_cnt[IDX_W-1-i];
        end

        // OUT_W leaves room for the largest shift, so no saturation needed.
        re_ext = {{(OUT_W-DATA_W){s_real[DATA_W-1]}}, s_real};
        im_ext = {{(OUT_W-DATA_W){s_imag[DATA_W-1]}}, s_imag};

        in_beat.re    = re_ext << eff_shift;
        in_beat.im    = im_ext << eff_shift;
        in_beat.chan  = s_chan;
        in_beat.index = eff_bitrev ? idx_rev : cur_cnt;
        in_beat.last  = (cur_cnt == LAST_IDX) || s_last;
    end

    // Per-channel frame counter and cfg latch. Any beat that closes a frame
    // (natural end, early s_last or missing s_last) restarts the count.
    always_comb begin
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        bitrev_d = bitrev_q;
        if (push) begin
            cnt_d[s_chan] = in_beat.last ? '0 : cur_cnt + IDX_W'(1);
            if (frame_start) begin
                shift_d[s_chan]  = shift_clamped;
                bitrev_d[s_chan] = cfg_bitrev;
            end
        end
    end

    // Skid buffer. out_q feeds m_*, skid_q catches the beat accepted in the
    // cycle where downstream stalls while s_ready was still high.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    out_d   = in_beat;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && m_ready) begin
                    out_d = in_beat;
                end else if (push) begin
                    skid_d  = in_beat;
                    state_d = ST_FULL;
                end else if (m_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (m_ready) begin
                    out_d   = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        s_ready_d = (state_d != ST_FULL);
        m_valid_d = (state_d != ST_EMPTY);
    end

    // Error pulses describe the beat accepted at the current edge.
    always_comb begin
        err_short_d  = push && s_last && (cur_cnt != LAST_IDX);
        err_long_d   = push && !s_last && (cur_cnt == LAST_IDX);
        err_chan_d   = accept && chan_bad;
        err_sticky_d = err_sticky_q || err_short_d || err_long_d || err_chan_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH_DEPTH; c++) begin
                cnt_q[c]    <= '0;
                shift_q[c]  <= '0;
                bitrev_q[c] <= 1'b0;
            end
            state_q      <= ST_EMPTY;
            out_q        <= '0;
            skid_q       <= '0;
            s_ready_q    <= 1'b1;
            m_valid_q    <= 1'b0;
            err_short_q  <= 1'b0;
            err_long_q   <= 1'b0;
            err_chan_q   <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            bitrev_q     <= bitrev_d;
            state_q      <= state_d;
            out_q        <= out_d;
            skid_q       <= skid_d;
            s_ready_q    <= s_ready_d;
            m_valid_q    <= m_valid_d;
            err_short_q  <= err_short_d;
            err_long_q   <= err_long_d;
            err_chan_q   <= err_chan_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign m_valid    = m_valid_q;
    assign m_real     = out_q.re;
    assign m_imag     = out_q.im;
    assign m_chan     = out_q.chan;
    assign m_index    = out_q.index;
    assign m_last     = out_q.last;
    assign err_short  = err_short_q;
    assign err_long   = err_long_q;
    assign err_chan   = err_chan_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_fft_frame_stage.sv
// ---------------------------------------------------------------------------
// tb_fft_frame_stage
//
// Self-checking bench for fft_frame_stage with N=8, NUM_CH=2, DATA_W=16.
// A reference model computes each beat's expected payload when it is
// accepted and queues it; the output monitor pops and compares on every
// output handshake. A second small instance with NUM_CH=3 exercises the
// out-of-range channel path, which a 2-channel instance cannot reach.
// ---------------------------------------------------------------------------
module tb_fft_frame_stage;

    localparam int N      = 8;
    localparam int DATA_W = 16;
    localparam int OUT_W  = DATA_W + 5;
    localparam int NUM_CH = 2;
    localparam int IDX_W  = 3;
    localparam int LIMIT  = 200;

    typedef struct {
        longint re;
        longint im;
        int     chan;
        int     index;
        bit     last;
    } exp_t;

    // Main DUT signals
    logic                    clk;
    logic                    rst_n;
    logic                    s_valid;
    logic                    s_ready;
    logic signed [DATA_W-1:0] s_real;
    logic signed [DATA_W-1:0] s_imag;
    logic [0:0]              s_chan;
    logic                    s_last;
    logic [2:0]              cfg_shift;
    logic                    cfg_bitrev;
    logic                    m_valid;
    logic                    m_ready;
    logic signed [OUT_W-1:0] m_real;
    logic signed [OUT_W-1:0] m_imag;
    logic [0:0]              m_chan;
    logic [IDX_W-1:0]        m_index;
    logic                    m_last;
    logic                    err_short;
    logic                    err_long;
    logic                    err_chan;
    logic                    err_sticky;

    // Second DUT (three channels) signals
    logic                    b_s_valid;
    logic                    b_s_ready;
    logic signed [DATA_W-1:0] b_s_real;
    logic signed [DATA_W-1:0] b_s_imag;
    logic [1:0]              b_s_chan;
    logic                    b_m_valid;
    logic signed [OUT_W-1:0] b_m_real;
    logic signed [OUT_W-1:0] b_m_imag;
    logic [1:0]              b_m_chan;
    logic [IDX_W-1:0]        b_m_index;
    logic                    b_m_last;
    logic                    b_err_short;
    logic                    b_err_long;
    logic                    b_err_chan;
    logic                    b_err_sticky;

    // Bench state
    int   n_checks;
    int   n_fail;
    exp_t sb_q[$];
    int   cnt_m    [NUM_CH];
    int   shift_m  [NUM_CH];
    bit   bitrev_m [NUM_CH];
    bit   exp_short;
    bit   exp_long;
    bit   exp_sticky;
    bit   checks_on;
    int   rdy_mode;

    fft_frame_stage #(
        .N(N), .DATA_W(DATA_W), .OUT_W(OUT_W), .NUM_CH(NUM_CH)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_real(s_real), .s_imag(s_imag), .s_chan(s_chan), .s_last(s_last),
        .cfg_shift(cfg_shift), .cfg_bitrev(cfg_bitrev),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_real(m_real), .m_imag(m_imag), .m_chan(m_chan),
        .m_index(m_index), .m_last(m_last),
        .err_short(err_short), .err_long(err_long), .err_chan(err_chan),
        .err_sticky(err_sticky)
    );

    fft_frame_stage #(
        .N(N), .DATA_W(DATA_W), .OUT_W(OUT_W), .NUM_CH(3)
    ) u_dut_chan (
        .clk(clk), .rst_n(rst_n),
        .s_valid(b_s_valid), .s_ready(b_s_ready),
        .s_real(b_s_real), .s_imag(b_s_imag), .s_chan(b_s_chan), .s_last(1'b0),
        .cfg_shift(3'd1), .cfg_bitrev(1'b0),
        .m_valid(b_m_valid), .m_ready(1'b1),
        .m_real(b_m_real), .m_imag(b_m_imag), .m_chan(b_m_chan),
        .m_index(b_m_index), .m_last(b_m_last),
        .err_short(b_err_short), .err_long(b_err_long), .err_chan(b_err_chan),
        .err_sticky(b_err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports every check.
    task automatic checkOutput(input string tag, input longint actual, input longint expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic int revIdx(input int v);
        int r;
        r = 0;
        for (int i = 0; i < IDX_W; i++) begin
            r = (r << 1) | ((v >> i) & 1);
        end
        return r;
    endfunction

    function automatic void modelReset();
        for (int c = 0; c < NUM_CH; c++) begin
            cnt_m[c]    = 0;
            shift_m[c]  = 0;
            bitrev_m[c] = 1'b0;
        end
        sb_q.delete();
        exp_short  = 1'b0;
        exp_long   = 1'b0;
        exp_sticky = 1'b0;
    endfunction

    // Reference behaviour of one accepted beat.
    task automatic modelAccept(input int re, input int im, input int ch,
                               input bit last, input int shift, input bit bitrev);
        exp_t e;
        int   c;
        c = cnt_m[ch];
        if (c == 0) begin
            shift_m[ch]  = (shift > 4) ? 4 : shift;
            bitrev_m[ch] = bitrev;
        end
        e.re    = longint'(re) * (longint'(1) << shift_m[ch]);
        e.im    = longint'(im) * (longint'(1) << shift_m[ch]);
        e.chan  = ch;
        e.index = bitrev_m[ch] ? revIdx(c) : c;
        e.last  = (c == N - 1) || last;
        exp_short = last && (c != N - 1);
        exp_long  = !last && (c == N - 1);
        cnt_m[ch] = e.last ? 0 : c + 1;
        sb_q.push_back(e);
    endtask

    // Drives one beat; called and returns at a falling edge.
    task automatic applyStimulus(input int re, input int im, input int ch,
                                 input bit last, input int shift, input bit bitrev);
        bit acc;
        int waited;
        s_valid    = 1'b1;
        s_real     = DATA_W'(re);
        s_imag     = DATA_W'(im);
        s_chan     = 1'(ch);
        s_last     = last;
        cfg_shift  = 3'(shift);
        cfg_bitrev = bitrev;
        acc        = 1'b0;
        waited     = 0;
        while (!acc && waited < LIMIT) begin
            acc = s_ready;
            @(posedge clk);
            if (acc) modelAccept(re, im, ch, last, shift, bitrev);
            @(negedge clk);
            waited++;
        end
        s_valid = 1'b0;
        if (!acc) checkOutput("accept_timeout", longint'(acc), 1);
    endtask

    task automatic waitDrain();
        int waited;
        waited = 0;
        while (sb_q.size() != 0 && waited < LIMIT) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("drain_pending", sb_q.size(), 0);
    endtask

    // Output monitor: buffer occupancy, error pulses, ready generation and
    // scoreboard comparison, all sampled at the falling edge.
    always @(negedge clk) begin
        if (checks_on) begin
            checkOutput("s_ready", s_ready, (sb_q.size() < 2) ? 1 : 0);
            checkOutput("m_valid", m_valid, (sb_q.size() != 0) ? 1 : 0);
            checkOutput("err_short", err_short, exp_short);
            checkOutput("err_long", err_long, exp_long);
            checkOutput("err_chan", err_chan, 0);
            exp_sticky = exp_sticky | exp_short | exp_long;
            checkOutput("err_sticky", err_sticky, exp_sticky);
            exp_short = 1'b0;
            exp_long  = 1'b0;
        end
        case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
        if (checks_on && m_valid && m_ready) begin
            if (sb_q.size() == 0) begin
                checkOutput("sb_nonempty", sb_q.size(), 1);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("m_real", longint'(m_real), e.re);
                checkOutput("m_imag", longint'(m_imag), e.im);
                checkOutput("m_chan", m_chan, e.chan);
                checkOutput("m_index", m_index, e.index);
                checkOutput("m_last", m_last, e.last);
            end
        end
    end

    initial begin
        int ch;
        n_checks   = 0;
        n_fail     = 0;
        checks_on  = 1'b0;
        rdy_mode   = 0;
        rst_n      = 1'b0;
        s_valid    = 1'b0;
        s_real     = '0;
        s_imag     = '0;
        s_chan     = '0;
        s_last     = 1'b0;
        cfg_shift  = '0;
        cfg_bitrev = 1'b0;
        m_ready    = 1'b0;
        b_s_valid  = 1'b0;
        b_s_real   = '0;
        b_s_imag   = '0;
        b_s_chan   = '0;
        modelReset();

        repeat (3) @(negedge clk);
        $display("[TB] reset values");
        checkOutput("rst_m_valid", m_valid, 0);
        checkOutput("rst_s_ready", s_ready, 1);
        checkOutput("rst_m_real", longint'(m_real), 0);
        checkOutput("rst_m_index", m_index, 0);
        checkOutput("rst_err_sticky", err_sticky, 0);
        rst_n = 1'b1;
        @(negedge clk);
        checks_on = 1'b1;

        $display("[TB] ch0 frame, shift 2");
        for (int i = 0; i < 8; i++) applyStimulus(i + 1, -i, 0, i == 7, 2, 1'b0);
        waitDrain();

        $display("[TB] bit-reversed frame, shift changed mid-frame");
        for (int i = 0; i < 8; i++) applyStimulus(10 * i - 7, i, 0, i == 7, (i < 4) ? 1 : 3, 1'b1);
        waitDrain();

        $display("[TB] interleaved channels");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(i, 1, 0, i == 7, 0, 1'b0);
            applyStimulus(100 + i, -2, 1, i == 7, 1, 1'b0);
        end
        waitDrain();

        $display("[TB] short and long frames");
        for (int i = 0; i < 5; i++) applyStimulus(i, 0, 0, i == 4, 0, 1'b0);
        for (int i = 0; i < 9; i++) applyStimulus(i, 0, 0, 1'b0, 0, 1'b0);
        for (int i = 1; i < 8; i++) applyStimulus(i, 0, 0, i == 7, 0, 1'b0);
        applyStimulus(-32768, 32767, 1, 1'b1, 7, 1'b0);
        waitDrain();

        $display("[TB] random backpressure");
        rdy_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            ch = $urandom_range(0, 1);
            applyStimulus(int'($urandom_range(0, 65535)) - 32768,
                          int'($urandom_range(0, 65535)) - 32768, ch,
                          (cnt_m[ch] == N - 1) ^ ($urandom_range(0, 19) == 0),
                          $urandom_range(0, 7), 1'($urandom_range(0, 1)));
        end
        rdy_mode = 0;
        waitDrain();

        $display("[TB] reset with full buffer");
        rdy_mode = 2;
        @(negedge clk);
        applyStimulus(11, 12, 0, 1'b0, 1, 1'b0);
        applyStimulus(13, 14, 1, 1'b0, 1, 1'b0);
        checkOutput("full_s_ready", s_ready, 0);
        checks_on = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_m_valid", m_valid, 0);
        checkOutput("mid_rst_s_ready", s_ready, 1);
        checkOutput("mid_rst_m_real", longint'(m_real), 0);
        checkOutput("mid_rst_m_index", m_index, 0);
        checkOutput("mid_rst_m_last", m_last, 0);
        checkOutput("mid_rst_m_chan", m_chan, 0);
        checkOutput("mid_rst_err_sticky", err_sticky, 0);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        rdy_mode = 0;
        @(negedge clk);
        checks_on = 1'b1;
        applyStimulus(21, 22, 1, 1'b0, 0, 1'b1);
        applyStimulus(23, 24, 1, 1'b0, 0, 1'b1);
        waitDrain();

        $display("[TB] out-of-range channel");
        b_s_valid = 1'b1;
        b_s_chan  = 2'd3;
        b_s_real  = 16'sd5;
        @(posedge clk);
        @(negedge clk);
        b_s_valid = 1'b0;
        checkOutput("b_err_chan", b_err_chan, 1);
        checkOutput("b_m_valid_drop", b_m_valid, 0);
        checkOutput("b_err_sticky", b_err_sticky, 1);
        @(negedge clk);
        checkOutput("b_err_chan_end", b_err_chan, 0);
        checkOutput("b_err_sticky_hold", b_err_sticky, 1);
        b_s_valid = 1'b1;
        b_s_chan  = 2'd2;
        b_s_real  = -16'sd3;
        @(posedge clk);
        @(negedge clk);
        b_s_valid = 1'b0;
        checkOutput("b_m_valid", b_m_valid, 1);
        checkOutput("b_m_chan", b_m_chan, 2);
        checkOutput("b_m_index", b_m_index, 0);
        checkOutput("b_m_real", longint'(b_m_real), -6);
        checkOutput("b_err_chan_ok", b_err_chan, 0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
